// File: rtl/step_pkg.sv
// step_controller shared types: FSM state encoding
// and the raw mode switch encodings.
package step_pkg;

  typedef enum logic [1:0] {
    HALTED   = 2'b00,
    STEP     = 2'b01,
    RUN_SLOW = 2'b10,
    RUN_FAST = 2'b11
  } state_t;

  localparam logic [1:0] MODE_HALT = 2'b00;
  localparam logic [1:0] MODE_STEP = 2'b01;
  localparam logic [1:0] MODE_SLOW = 2'b10;
  localparam logic [1:0] MODE_FAST = 2'b11;

endpackage

// File: rtl/debouncer.sv
// Level debouncer: accepts a new level only after it
// has held for DEBOUNCE_CYCLES consecutive cycles.
module debouncer #(
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_in,
  input  logic rst_n,
  input  logic raw,
  output logic stable
);

  localparam int CW =
    ($clog2(DEBOUNCE_CYCLES) < 1) ? 1 :
    $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST =
    CW'(DEBOUNCE_CYCLES - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      stable <= 1'b1;
      cnt    <= '0;
    end else if (raw == stable) begin
      cnt <= '0;
    end else if (cnt == LAST) begin
      stable <= raw;
      cnt    <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/step_controller.sv
// CPU clock-enable controller: halt / single-step /
// slow-run / fast-run, with halt latch and step counter.
module step_controller
  import step_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int CNT_W           = 32
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             slow_clk,
  input  logic             step_btn_n,
  input  logic [1:0]       mode_sw,
  input  logic             halt_req,
  output logic             cpu_en,
  output logic [CNT_W-1:0] step_count,
  output logic [1:0]       state
);

  logic [1:0] btn_sync;
  logic [1:0] mode_s1;
  logic [1:0] mode_s2;
  logic       btn_db;
  logic       btn_db_q;
  logic       slow_q;
  logic       halt_q;
  state_t     state_q;

  logic press;
  logic tick;
  logic fire;
  logic halt_next;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      btn_sync <= 2'b11;
      mode_s1  <= MODE_HALT;
      mode_s2  <= MODE_HALT;
    end else begin
      btn_sync <= {btn_sync[0], step_btn_n};
      mode_s1  <= mode_sw;
      mode_s2  <= mode_s1;
    end
  end

  debouncer #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debouncer (
    .clk_in (clk_in),
    .rst_n  (rst_n),
    .raw    (btn_sync[1]),
    .stable (btn_db)
  );

  assign press = btn_db_q & ~btn_db;
  assign tick  = slow_clk & ~slow_q;

  // Enable is judged against the current (old) state.
  always_comb begin
    fire = 1'b0;
    unique case (1'b1)
      state_q == STEP:     fire = press;
      state_q == RUN_SLOW: fire = tick;
      state_q == RUN_FAST: fire = 1'b1;
      default:             fire = 1'b0;
    endcase
    if (halt_req || halt_q) fire = 1'b0;
  end

  assign halt_next = halt_req |
    (halt_q & (mode_s2 != MODE_HALT));

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      btn_db_q   <= 1'b1;
      slow_q     <= 1'b0;
      halt_q     <= 1'b0;
      state_q    <= HALTED;
      cpu_en     <= 1'b0;
      step_count <= '0;
    end else begin
      btn_db_q   <= btn_db;
      slow_q     <= slow_clk;
      halt_q     <= halt_next;
      state_q    <= halt_next ? HALTED
                              : state_t'(mode_s2);
      cpu_en     <= fire;
      step_count <= step_count + CNT_W'(fire);
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_step_controller.sv
// Self-checking bench for step_controller: mode table,
// directed corner sequences and a randomized model run.
module tb_step_controller;

  localparam int DEB = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       slow_clk = 1'b0;
  logic       step_btn_n = 1'b1;
  logic [1:0] mode_sw = 2'b00;
  logic       halt_req = 1'b0;
  logic       cpu_en;
  logic [3:0] step_count;
  logic [1:0] state;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always #5 clk = ~clk;

  step_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .CNT_W(4)
  ) dut (
    .clk_in     (clk),
    .rst_n      (rst_n),
    .slow_clk   (slow_clk),
    .step_btn_n (step_btn_n),
    .mode_sw    (mode_sw),
    .halt_req   (halt_req),
    .cpu_en     (cpu_en),
    .step_count (step_count),
    .state      (state)
  );

  // Reference: inputs seen through 2-sample delay
  // lines, a run-length debouncer and the mode rules.
  logic [1:0] m_md1, m_md2, m_msync, m_state;
  logic       m_bd1, m_bd2, m_bsync, m_deb, m_fell;
  logic       m_slow_prev, m_latch, m_en, m_fire;
  logic [3:0] m_cnt;
  int         m_run;

  task automatic model_reset();
    m_md1 = 0; m_md2 = 0; m_bd1 = 1; m_bd2 = 1;
    m_deb = 1; m_fell = 0; m_run = 0;
    m_slow_prev = 0; m_latch = 0; m_state = 0;
    m_en = 0; m_cnt = 0;
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      m_msync = m_md2;
      m_bsync = m_bd2;
      case (m_state)
        2'd1:    m_fire = m_fell;
        2'd2:    m_fire = slow_clk && !m_slow_prev;
        2'd3:    m_fire = 1'b1;
        default: m_fire = 1'b0;
      endcase
      if (halt_req || m_latch) m_fire = 1'b0;
      m_en = m_fire;
      m_cnt = m_cnt + {3'b0, m_fire};
      m_latch = halt_req || (m_latch && m_msync != 0);
      m_state = m_latch ? 2'd0 : m_msync;
      m_fell = 1'b0;
      if (m_bsync == m_deb) begin
        m_run = 0;
      end else begin
        m_run++;
        if (m_run == DEB) begin
          m_fell = m_deb && !m_bsync;
          m_deb = m_bsync;
          m_run = 0;
        end
      end
      m_md2 = m_md1; m_md1 = mode_sw;
      m_bd2 = m_bd1; m_bd1 = step_btn_n;
      m_slow_prev = slow_clk;
    end
  end

  task automatic check(string name,
                       logic [31:0] act,
                       logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d",
               name, act, exp);
    end
  endtask

  task automatic step(int n = 1);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("model_en", cpu_en, m_en);
      check("model_cnt", step_count, m_cnt);
      check("model_state", state, m_state);
      if (cpu_en) pulses++;
    end
  endtask

  task automatic check_reset_now(string tag);
    check({tag, "_en"}, cpu_en, 0);
    check({tag, "_cnt"}, step_count, 0);
    check({tag, "_state"}, state, 0);
  endtask

  typedef struct {
    logic [1:0] mode;
    logic [1:0] exp_state;
    logic       exp_en;
  } vec_t;

  vec_t vecs[6];

  initial begin
    logic [3:0] c0;
    int rise;
    vecs[0] = '{2'd1, 2'd1, 1'b0};
    vecs[1] = '{2'd2, 2'd2, 1'b0};
    vecs[2] = '{2'd3, 2'd3, 1'b1};
    vecs[3] = '{2'd0, 2'd0, 1'b0};
    vecs[4] = '{2'd3, 2'd3, 1'b1};
    vecs[5] = '{2'd1, 2'd1, 1'b0};

    step(3);
    rst_n = 1'b1;
    check_reset_now("rst_init");
    step(2);

    foreach (vecs[i]) begin
      mode_sw = vecs[i].mode;
      step(4);
      check("tbl_state", state, vecs[i].exp_state);
      check("tbl_en", cpu_en, vecs[i].exp_en);
    end

    // Bouncing press in STEP mode.
    pulses = 0;
    c0 = m_cnt;
    for (int g = 0; g < 3; g++) begin
      step_btn_n = 0; step();
      step_btn_n = 1; step();
    end
    step_btn_n = 0; step(10);
    step_btn_n = 1; step(12);
    check("press_pulses", pulses, 1);
    check("press_cnt", step_count, 4'(c0 + 1));

    // Slow run: pulse exactly one cycle after rise.
    mode_sw = 2'd2; step(4);
    pulses = 0;
    for (int i = 0; i < 50; i++) begin
      rise = (i % 10 == 5);
      slow_clk = ((i / 5) % 2 == 1);
      step();
      check("slow_align", cpu_en, rise);
    end
    slow_clk = 0;
    check("slow_pulses", pulses, 5);

    // Halt latch.
    mode_sw = 2'd3; step(20);
    check("fast_en", cpu_en, 1);
    halt_req = 1; step();
    halt_req = 0;
    check("halt_drop", cpu_en, 0);
    pulses = 0;
    step(10);
    check("halt_hold", pulses, 0);
    check("halt_state", state, 0);
    mode_sw = 2'd0; step(4);
    mode_sw = 2'd3; step(5);
    check("resume_en", cpu_en, 1);
    check("resume_state", state, 3);

    // Counter wrap.
    for (int i = 0; i < 20 && m_cnt != 4'd14; i++)
      step();
    check("wrap_pre", step_count, 14);
    step(); check("wrap_15", step_count, 15);
    step(); check("wrap_0", step_count, 0);
    step(); check("wrap_1", step_count, 1);

    // Reset during RUN_FAST.
    rst_n = 0; #1;
    check_reset_now("rst_fast");
    step(2);
    rst_n = 1;
    pulses = 0;
    step(2);
    check("rst_fast_rel", pulses, 0);
    check("rst_fast_st", state, 0);

    // Reset mid-debounce in STEP mode.
    mode_sw = 2'd1; step(4);
    step_btn_n = 0; step(4);
    rst_n = 0; #1;
    check_reset_now("rst_deb");
    step_btn_n = 1;
    step(2);
    rst_n = 1;
    pulses = 0;
    step(10);
    check("rst_deb_rel", pulses, 0);

    // Press while halted is not queued.
    mode_sw = 2'd0; step(4);
    pulses = 0;
    step_btn_n = 0; step(10);
    step_btn_n = 1; step(2);
    mode_sw = 2'd1; step(15);
    check("halt_press", pulses, 0);

    // Randomized run against the model.
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 15) == 0)
        mode_sw = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 5) == 0)
        step_btn_n = ~step_btn_n;
      if ($urandom_range(0, 3) == 0)
        slow_clk = ~slow_clk;
      halt_req = ($urandom_range(0, 60) == 0);
      step();
    end
    halt_req = 0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
